// File: rtl/audio_sample_packet_receiver.sv
// HDMI audio sample packet (type 0x02, 2-channel layout 0) sink: unpacks subpackets,
// checks IEC 60958 parity, rebuilds channel status and queues stereo samples in a FIFO.
module audio_sample_packet_receiver #(
    parameter int FIFO_DEPTH         = 8,
    parameter bit DROP_PARITY_ERRORS = 1'b0
) (
    input  logic         clk_pixel,
    input  logic         reset_n,
    input  logic         packet_valid,
    input  logic [23:0]  header,
    input  logic [223:0] sub,
    output logic         busy,
    output logic         sample_valid,
    input  logic         sample_ready,
    output logic [23:0]  sample_left,
    output logic [23:0]  sample_right,
    output logic [7:0]   sample_flags,
    output logic         sample_block_start,
    output logic         cs_update,
    output logic         cs_valid,
    output logic [39:0]  cs_left,
    output logic [39:0]  cs_right,
    output logic [15:0]  parity_error_count,
    output logic         overflow,
    output logic         layout_error
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic {IDLE, UNPACK} state_t;

    state_t       state;
    logic [1:0]   slot;
    logic [3:0]   mask_q;
    logic [3:0]   b_q;
    logic [223:0] sub_q;
    logic [55:0]  sp;
    logic [56:0]  mem [FIFO_DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [7:0]   cs_idx;
    logic         cs_lock;
    logic [39:0]  shadow_l;
    logic [39:0]  shadow_r;
    logic [56:0]  head;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        sp = sub_q[55:0];
        case (slot)
            2'd1:    sp = sub_q[111:56];
            2'd2:    sp = sub_q[167:112];
            2'd3:    sp = sub_q[223:168];
            default: sp = sub_q[55:0];
        endcase
    end

    logic pkt_hit, present, bflag, fail_l, fail_r, par_fail, want_wr;
    logic empty, full, pop, push;

    assign pkt_hit  = packet_valid && (header[7:0] == 8'h02);
    assign present  = (state == UNPACK) && mask_q[slot];
    assign bflag    = b_q[slot];
    assign fail_l   = ^{sp[23:0], sp[51:48]};
    assign fail_r   = ^{sp[47:24], sp[55:52]};
    assign par_fail = fail_l | fail_r;
    assign want_wr  = present && !(DROP_PARITY_ERRORS && par_fail);
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop      = !empty && sample_ready;
    // A full FIFO still accepts a write when the head is popping in the same cycle.
    assign push     = want_wr && (!full || pop);

    assign busy         = (state == UNPACK);
    assign sample_valid = !empty;
    assign head         = mem[rd_ptr[AW-1:0]];
    // Storage is not reset, so the head is masked while the FIFO is empty.
    assign sample_left        = sample_valid ? head[56:33] : 24'd0;
    assign sample_right       = sample_valid ? head[32:9]  : 24'd0;
    assign sample_flags       = sample_valid ? head[8:1]   : 8'd0;
    assign sample_block_start = sample_valid ? head[0]     : 1'b0;

    always_ff @(posedge clk_pixel) begin
        if (state == IDLE && pkt_hit && !header[12])
            sub_q <= sub;
        if (push)
            mem[wr_ptr[AW-1:0]] <= {sp[23:0], sp[47:24], sp[55:48], bflag};
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            state              <= IDLE;
            slot               <= 2'd0;
            mask_q             <= 4'd0;
            b_q                <= 4'd0;
            wr_ptr             <= '0;
            rd_ptr             <= '0;
            cs_idx             <= 8'd0;
            cs_lock            <= 1'b0;
            shadow_l           <= 40'd0;
            shadow_r           <= 40'd0;
            cs_update          <= 1'b0;
            cs_valid           <= 1'b0;
            cs_left            <= 40'd0;
            cs_right           <= 40'd0;
            parity_error_count <= 16'd0;
            overflow           <= 1'b0;
            layout_error       <= 1'b0;
        end else begin
            cs_update <= 1'b0;
            case (state)
                IDLE: begin
                    if (pkt_hit) begin
                        if (header[12]) begin
                            layout_error <= 1'b1;
                        end else begin
                            state  <= UNPACK;
                            slot   <= 2'd0;
                            mask_q <= header[11:8];
                            b_q    <= header[23:20];
                        end
                    end
                end
                default: begin
                    if (pkt_hit)
                        overflow <= 1'b1;
                    slot <= slot + 2'd1;
                    if (slot == 2'd3)
                        state <= IDLE;
                end
            endcase

            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (want_wr && full && !pop)
                overflow <= 1'b1;

            if (present && par_fail)
                parity_error_count <= sat_inc16(parity_error_count);

            // Channel status: index counts frames since the last B; index 0 while locked
            // means the previous block just closed and a B is required next.
            if (present) begin
                if (bflag) begin
                    cs_idx   <= 8'd1;
                    cs_lock  <= 1'b1;
                    shadow_l <= {39'd0, sp[50]};
                    shadow_r <= {39'd0, sp[54]};
                end else if (cs_lock) begin
                    if (cs_idx == 8'd0) begin
                        cs_lock <= 1'b0;
                    end else begin
                        for (int k = 1; k < 40; k++) begin
                            if (cs_idx == 8'(k)) begin
                                shadow_l[k] <= sp[50];
                                shadow_r[k] <= sp[54];
                            end
                        end
                        if (cs_idx == 8'd191) begin
                            cs_left   <= shadow_l;
                            cs_right  <= shadow_r;
                            cs_update <= 1'b1;
                            cs_valid  <= 1'b1;
                            cs_idx    <= 8'd0;
                        end else begin
                            cs_idx <= cs_idx + 8'd1;
                        end
                    end
                end
            end
        end
    end
endmodule
